// File: rtl/mm_pkg.sv
// Shared types and default widths for the matrix-multiply address sequencer.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  localparam int unsigned DEF_IN_AW   = 11;
  localparam int unsigned DEF_W_AW    = 13;
  localparam int unsigned DEF_OUT_AW  = 11;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_N_W     = 16;
  localparam int unsigned DEF_ACC_LAT = 2;

endpackage

// File: rtl/mm_wr_delay.sv
// Valid+address shift register that aligns the output write strobe with the MAC latency.
module mm_wr_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 11
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          pending
);

  logic          vld [DEPTH];
  logic [AW-1:0] adr [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        vld[i] <= 1'b0;
        adr[i] <= '0;
      end
    end else begin
      vld[0] <= push;
      adr[0] <= push_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  // Entries that will still be in the line after the current shift.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) pending = pending | vld[i];
  end

  assign out_valid = vld[DEPTH-1];
  assign out_addr  = adr[DEPTH-1];

endmodule

// File: rtl/mm_addr_seq.sv
// Address sequencer walking the N x Co x Ci loop nest of the dense matrix-multiply engine.
// Optional bias read port enabled by defining MM_BIAS_ADDR_EN.
module mm_addr_seq
  import mm_pkg::*;
#(
  parameter int unsigned IN_AW   = DEF_IN_AW,
  parameter int unsigned W_AW    = DEF_W_AW,
  parameter int unsigned OUT_AW  = DEF_OUT_AW,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned N_W     = DEF_N_W,
  parameter int unsigned ACC_LAT = DEF_ACC_LAT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [IN_AW-1:0]  cfg_in_base,
  input  logic [W_AW-1:0]   cfg_w_base,
  input  logic [OUT_AW-1:0] cfg_out_base,
  input  logic [CNT_W-1:0]  cfg_ci,
  input  logic [CNT_W-1:0]  cfg_co,
  input  logic [N_W-1:0]    cfg_n,
`ifdef MM_BIAS_ADDR_EN
  input  logic [W_AW-1:0]   cfg_bias_base,
  output logic              bias_rd_valid,
  output logic [W_AW-1:0]   bias_rd_addr,
`endif
  input  logic              rd_ready,
  output logic              in_rd_valid,
  output logic [IN_AW-1:0]  in_rd_addr,
  output logic              w_rd_valid,
  output logic [W_AW-1:0]   w_rd_addr,
  output logic              ci_last,
  output logic              out_wr_valid,
  output logic [OUT_AW-1:0] out_wr_addr,
  output logic              busy,
  output logic              done
);

  state_t state, state_n;

  logic [CNT_W-1:0]  ci_m1, co_m1, ci_cnt, co_cnt;
  logic [N_W-1:0]    n_m1, n_cnt;
  logic [IN_AW-1:0]  ci_len, in_row, in_ptr;
  logic [W_AW-1:0]   w_base_q, w_ptr;
  logic [OUT_AW-1:0] out_ptr;
  logic              beat, co_last, n_last, wr_pending, accept_start, cfg_zero;
`ifdef MM_BIAS_ADDR_EN
  logic [W_AW-1:0]   bias_base_q, bias_ptr;
`endif

  assign accept_start = (state == IDLE) && start;
  assign cfg_zero     = (cfg_ci == '0) || (cfg_co == '0) || (cfg_n == '0);
  assign beat         = (state == RUN) && rd_ready;
  assign ci_last      = (state == RUN) && (ci_cnt == ci_m1);
  assign co_last      = (co_cnt == co_m1);
  assign n_last       = (n_cnt == n_m1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = cfg_zero ? FIN : RUN;
      RUN:     if (beat && ci_last && co_last && n_last) state_n = DRAIN;
      DRAIN:   if (!wr_pending) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ci_m1    <= '0;
      co_m1    <= '0;
      n_m1     <= '0;
      ci_len   <= '0;
      w_base_q <= '0;
      ci_cnt   <= '0;
      co_cnt   <= '0;
      n_cnt    <= '0;
      in_row   <= '0;
      in_ptr   <= '0;
      w_ptr    <= '0;
      out_ptr  <= '0;
`ifdef MM_BIAS_ADDR_EN
      bias_base_q <= '0;
      bias_ptr    <= '0;
`endif
    end else if (accept_start) begin
      ci_m1    <= cfg_ci - CNT_W'(1);
      co_m1    <= cfg_co - CNT_W'(1);
      n_m1     <= cfg_n - N_W'(1);
      ci_len   <= IN_AW'(cfg_ci);
      w_base_q <= cfg_w_base;
      ci_cnt   <= '0;
      co_cnt   <= '0;
      n_cnt    <= '0;
      in_row   <= cfg_in_base;
      in_ptr   <= cfg_in_base;
      w_ptr    <= cfg_w_base;
      out_ptr  <= cfg_out_base;
`ifdef MM_BIAS_ADDR_EN
      bias_base_q <= cfg_bias_base;
      bias_ptr    <= cfg_bias_base;
`endif
    end else if (beat) begin
      if (!ci_last) begin
        ci_cnt <= ci_cnt + CNT_W'(1);
        in_ptr <= in_ptr + IN_AW'(1);
        w_ptr  <= w_ptr + W_AW'(1);
      end else begin
        ci_cnt  <= '0;
        out_ptr <= out_ptr + OUT_AW'(1);
        if (!co_last) begin
          // Same feature row, next weight row: weights are contiguous across co.
          co_cnt <= co_cnt + CNT_W'(1);
          in_ptr <= in_row;
          w_ptr  <= w_ptr + W_AW'(1);
`ifdef MM_BIAS_ADDR_EN
          bias_ptr <= bias_ptr + W_AW'(1);
`endif
        end else begin
          co_cnt <= '0;
          n_cnt  <= n_cnt + N_W'(1);
          in_row <= in_row + ci_len;
          in_ptr <= in_row + ci_len;
          w_ptr  <= w_base_q;
`ifdef MM_BIAS_ADDR_EN
          bias_ptr <= bias_base_q;
`endif
        end
      end
    end
  end

  mm_wr_delay #(
    .DEPTH (ACC_LAT),
    .AW    (OUT_AW)
  ) u_wr_delay (
    .clk       (clk),
    .rstn      (rstn),
    .push      (beat && ci_last),
    .push_addr (out_ptr),
    .out_valid (out_wr_valid),
    .out_addr  (out_wr_addr),
    .pending   (wr_pending)
  );

  assign in_rd_valid = (state == RUN);
  assign w_rd_valid  = (state == RUN);
  assign in_rd_addr  = in_ptr;
  assign w_rd_addr   = w_ptr;
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == FIN);

`ifdef MM_BIAS_ADDR_EN
  assign bias_rd_valid = beat && (ci_cnt == '0);
  assign bias_rd_addr  = bias_ptr;
`endif

endmodule

// File: tb/tb_mm_addr_seq.sv
// Self-checking bench for mm_addr_seq: loop-nest reference model with timed write scoreboard.
module tb_mm_addr_seq;

  localparam int unsigned IN_AW  = 11;
  localparam int unsigned W_AW   = 13;
  localparam int unsigned OUT_AW = 11;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned N_W    = 16;
  localparam int unsigned LAT    = 2;
  localparam int unsigned IN_M   = (1 << IN_AW) - 1;
  localparam int unsigned W_M    = (1 << W_AW) - 1;
  localparam int unsigned OUT_M  = (1 << OUT_AW) - 1;
  localparam int unsigned NEVER  = 32'h0FFF_FFFF;

  logic              clk, rstn, start, rd_ready;
  logic [IN_AW-1:0]  cfg_in_base;
  logic [W_AW-1:0]   cfg_w_base;
  logic [OUT_AW-1:0] cfg_out_base;
  logic [CNT_W-1:0]  cfg_ci, cfg_co;
  logic [N_W-1:0]    cfg_n;
  logic              in_rd_valid, w_rd_valid, ci_last, out_wr_valid, busy, done;
  logic [IN_AW-1:0]  in_rd_addr;
  logic [W_AW-1:0]   w_rd_addr;
  logic [OUT_AW-1:0] out_wr_addr;
`ifdef MM_BIAS_ADDR_EN
  logic [W_AW-1:0]   cfg_bias_base;
  logic              bias_rd_valid;
  logic [W_AW-1:0]   bias_rd_addr;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mm_addr_seq #(
    .IN_AW   (IN_AW),
    .W_AW    (W_AW),
    .OUT_AW  (OUT_AW),
    .CNT_W   (CNT_W),
    .N_W     (N_W),
    .ACC_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .cfg_in_base  (cfg_in_base),
    .cfg_w_base   (cfg_w_base),
    .cfg_out_base (cfg_out_base),
    .cfg_ci       (cfg_ci),
    .cfg_co       (cfg_co),
    .cfg_n        (cfg_n),
`ifdef MM_BIAS_ADDR_EN
    .cfg_bias_base (cfg_bias_base),
    .bias_rd_valid (bias_rd_valid),
    .bias_rd_addr  (bias_rd_addr),
`endif
    .rd_ready     (rd_ready),
    .in_rd_valid  (in_rd_valid),
    .in_rd_addr   (in_rd_addr),
    .w_rd_valid   (w_rd_valid),
    .w_rd_addr    (w_rd_addr),
    .ci_last      (ci_last),
    .out_wr_valid (out_wr_valid),
    .out_wr_addr  (out_wr_addr),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned ia, wa, oa, ba;
    bit          last, first;
  } beat_t;

  typedef struct {
    int unsigned t, a;
  } wr_t;

  task automatic check_idle_outputs(input string tag);
    check({tag, ".in_valid"}, in_rd_valid, 0);
    check({tag, ".w_valid"}, w_rd_valid, 0);
    check({tag, ".in_addr"}, in_rd_addr, 0);
    check({tag, ".w_addr"}, w_rd_addr, 0);
    check({tag, ".ci_last"}, ci_last, 0);
    check({tag, ".wr_valid"}, out_wr_valid, 0);
    check({tag, ".wr_addr"}, out_wr_addr, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
`ifdef MM_BIAS_ADDR_EN
    check({tag, ".bias_valid"}, bias_rd_valid, 0);
    check({tag, ".bias_addr"}, bias_rd_addr, 0);
`endif
  endtask

  task automatic drive_cfg(input int unsigned ib, wb, ob, bb, ci, co, n);
    cfg_in_base  = IN_AW'(ib);
    cfg_w_base   = W_AW'(wb);
    cfg_out_base = OUT_AW'(ob);
    cfg_ci       = CNT_W'(ci);
    cfg_co       = CNT_W'(co);
    cfg_n        = N_W'(n);
`ifdef MM_BIAS_ADDR_EN
    cfg_bias_base = W_AW'(bb);
`else
    if (bb != 0) begin end
`endif
  endtask

  // mode 0: always ready, 1: ready toggles 1,0,..., 2: random ready
  task automatic run_case(input int unsigned ib, wb, ob, bb, ci, co, n,
                          input int unsigned mode, input bit poke_start);
    beat_t       beats[$];
    wr_t         wq[$];
    beat_t       b;
    wr_t         w;
    int unsigned idx, nb, done_at, cyc;
    bit          acc, exp_wr, finished;

    for (int unsigned nn = 0; nn < n; nn++)
      for (int unsigned cc = 0; cc < co; cc++)
        for (int unsigned k = 0; k < ci; k++) begin
          b.ia    = (ib + nn * ci + k) & IN_M;
          b.wa    = (wb + cc * ci + k) & W_M;
          b.oa    = (ob + nn * co + cc) & OUT_M;
          b.ba    = (bb + cc) & W_M;
          b.last  = (k == ci - 1);
          b.first = (k == 0);
          beats.push_back(b);
        end
    nb       = beats.size();
    idx      = 0;
    done_at  = (nb == 0) ? 1 : NEVER;
    finished = 1'b0;

    @(posedge clk); #1;
    drive_cfg(ib, wb, ob, bb, ci, co, n);
    start    = 1'b1;
    rd_ready = 1'b0;
    @(posedge clk); #1;
    cyc = 1;

    while (!finished) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = cyc[0];
        default: rd_ready = ($urandom_range(0, 3) != 0);
      endcase
      start = poke_start && (cyc == 3);
      if (start) drive_cfg($urandom, $urandom, $urandom, $urandom, 1, 1, 1);
      #1;

      check("in_rd_valid", in_rd_valid, idx < nb);
      check("w_rd_valid", w_rd_valid, idx < nb);
      acc = (idx < nb) && rd_ready;
      if (idx < nb) begin
        check("in_rd_addr", in_rd_addr, beats[idx].ia);
        check("w_rd_addr", w_rd_addr, beats[idx].wa);
        check("ci_last", ci_last, beats[idx].last);
      end
`ifdef MM_BIAS_ADDR_EN
      check("bias_rd_valid", bias_rd_valid, acc && beats[idx].first);
      if (acc && beats[idx].first) check("bias_rd_addr", bias_rd_addr, beats[idx].ba);
`endif
      if (acc) begin
        if (beats[idx].last) begin
          w.t = cyc + LAT;
          w.a = beats[idx].oa;
          wq.push_back(w);
          if (idx == nb - 1) done_at = cyc + LAT + 1;
        end
        idx++;
      end

      exp_wr = (wq.size() > 0) && (wq[0].t == cyc);
      check("out_wr_valid", out_wr_valid, exp_wr);
      if (exp_wr) begin
        check("out_wr_addr", out_wr_addr, wq[0].a);
        void'(wq.pop_front());
      end
      check("done", done, cyc == done_at);
      check("busy", busy, (nb > 0) && (cyc < done_at));

      if (cyc >= done_at + 2) finished = 1'b1;
      else if (cyc > 4000) begin
        check("timeout", idx, nb + 1);
        finished = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("wr_left", wq.size(), 0);
  endtask

  task automatic reset_mid_run();
    @(posedge clk); #1;
    drive_cfg(32'h10, 32'h100, 32'h20, 32'h200, 2, 2, 2);
    start    = 1'b1;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy", busy, 1);
    rstn = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    check_idle_outputs("held_reset");
    rstn = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_reset_done", done, 0);
      check("post_reset_wr", out_wr_valid, 0);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    rd_ready = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 1'b1;

    run_case(32'h10, 32'h100, 32'h20, 32'h200, 2, 2, 2, 0, 1'b0);
    run_case(32'h10, 32'h100, 32'h20, 32'h200, 2, 2, 2, 1, 1'b0);
    run_case(32'h10, 32'h100, 32'h20, 32'h200, 0, 2, 2, 0, 1'b0);
    run_case(32'h10, 32'h100, 32'h20, 32'h200, 2, 0, 2, 0, 1'b0);
    run_case(32'h10, 32'h100, 32'h20, 32'h200, 2, 2, 0, 0, 1'b0);
    run_case(32'h40, 32'h80, 32'h5, 32'h300, 1, 3, 1, 0, 1'b0);
    reset_mid_run();
    run_case(32'h10, 32'h100, 32'h20, 32'h200, 2, 2, 2, 0, 1'b1);
    run_case(IN_M - 2, W_M - 3, OUT_M - 1, W_M, 3, 2, 2, 2, 1'b1);
    for (int i = 0; i < 12; i++)
      run_case($urandom, $urandom, $urandom, $urandom,
               $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3),
               $urandom_range(0, 2), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
